// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared pong types and constants for the score keeper
package score_keeper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int SCORE_W = 4;
  localparam logic [SCORE_W-1:0] MAX_DIGIT = 4'd9;

  localparam logic DIR_P1 = 1'b0;
  localparam logic DIR_P2 = 1'b1;

  // Display digits must never carry the renderer's blanking codes 10..15.
  function automatic logic [SCORE_W-1:0] clamp_digit(input logic [SCORE_W-1:0] v);
    return (v > MAX_DIGIT) ? MAX_DIGIT : v;
  endfunction

endpackage

// File: rtl/score_keeper_frame_counter.sv
// rtl/score_keeper_frame_counter.sv - loadable frame-paced down-counter with terminal strobe
module score_keeper_frame_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  input  logic         tick,
  output logic         terminal
);

  logic [W-1:0] count;

  // A count of 0 also fires so a zero-length delay ends on the first tick.
  assign terminal = en && tick && (count <= W'(1));

  // Load wins over a same-cycle tick; the counter rests at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - pong score, serve delay and game-over sequencer
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               out_left,
  input  logic               out_right,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               serve_go,
  output logic               serve_dir,
  output logic               playing,
  output logic               game_over,
  output logic               winner
);

  localparam int CNT_W = $clog2(SERVE_DELAY + 2);
  localparam logic [CNT_W-1:0]   DELAY_LD = CNT_W'(SERVE_DELAY);
  localparam logic [SCORE_W-1:0] WIN_LD   = SCORE_W'(WIN_SCORE);

  state_t state, state_next;

  logic [SCORE_W-1:0] p1_int, p2_int, p1_d, p2_d;
  logic               dir_d, winner_d, serve_go_d;
  logic               cnt_load, cnt_done, win;

  assign win = (p1_int == WIN_LD) || (p2_int == WIN_LD);

  score_keeper_frame_counter #(
    .W (CNT_W)
  ) u_serve_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (DELAY_LD),
    .en         (state == ST_SERVE),
    .tick       (frame_tick),
    .terminal   (cnt_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; simultaneous exits cancel and start only acts when idle or over.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SERVE;
      ST_SERVE: if (cnt_done) state_next = ST_PLAY;
      ST_PLAY:  if (out_left ^ out_right) state_next = ST_POINT;
      ST_POINT: state_next = win ? ST_OVER : ST_SERVE;
      ST_OVER:  if (start) state_next = ST_SERVE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Per-state updates for scores, serve direction, winner and counter reload.
  always_comb begin
    p1_d       = p1_int;
    p2_d       = p2_int;
    dir_d      = serve_dir;
    winner_d   = winner;
    cnt_load   = 1'b0;
    serve_go_d = (state == ST_SERVE) && cnt_done;
    case (state)
      ST_IDLE: begin
        if (start) begin
          p1_d     = '0;
          p2_d     = '0;
          cnt_load = 1'b1;
        end
      end
      ST_PLAY: begin
        if (out_left && !out_right) begin
          p2_d  = p2_int + 1'b1;
          dir_d = DIR_P1;
        end else if (out_right && !out_left) begin
          p1_d  = p1_int + 1'b1;
          dir_d = DIR_P2;
        end
      end
      ST_POINT: begin
        if (win) begin
          winner_d = (p2_int == WIN_LD) ? DIR_P2 : DIR_P1;
        end else begin
          cnt_load = 1'b1;
        end
      end
      ST_OVER: begin
        if (start) begin
          p1_d     = '0;
          p2_d     = '0;
          dir_d    = DIR_P1;
          cnt_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs; displayed scores follow the internal ones only on frame_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_int    <= '0;
      p2_int    <= '0;
      score_p1  <= '0;
      score_p2  <= '0;
      serve_go  <= 1'b0;
      serve_dir <= DIR_P1;
      playing   <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      p1_int    <= p1_d;
      p2_int    <= p2_d;
      serve_go  <= serve_go_d;
      serve_dir <= dir_d;
      winner    <= winner_d;
      playing   <= (state_next == ST_PLAY);
      game_over <= (state_next == ST_OVER);
      if (frame_tick) begin
        score_p1 <= clamp_digit(p1_int);
        score_p2 <= clamp_digit(p2_int);
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed vector and sequence bench for score_keeper
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       out_left = 1'b0;
  logic       out_right = 1'b0;
  logic [3:0] score_p1, score_p2;
  logic       serve_go, serve_dir, playing, game_over, winner;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       st, ft, ol, orr;
    logic [3:0] p1, p2;
    logic       go, dir, ply, ovr;
  } vec_t;

  vec_t vecs [17];

  score_keeper #(
    .WIN_SCORE   (9),
    .SERVE_DELAY (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .out_left   (out_left),
    .out_right  (out_right),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .serve_go   (serve_go),
    .serve_dir  (serve_dir),
    .playing    (playing),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] outs();
    return {4'h0, score_p1, score_p2, serve_go, serve_dir, playing, game_over};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic ft, input logic ol, input logic orr);
    start = st; frame_tick = ft; out_left = ol; out_right = orr;
    @(posedge clk);
    #1;
    start = 1'b0; frame_tick = 1'b0; out_left = 1'b0; out_right = 1'b0;
  endtask

  task automatic serve_wait();
    for (int i = 0; i < 20 && !playing; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("serve_reached_play", {15'd0, playing}, 16'd1);
  endtask

  task automatic point(input logic left);
    step(1'b0, 1'b0, left, !left);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    //           st    ft    ol    or    p1    p2    go    dir   ply   ovr
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {outs()[15:1], winner}, 16'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].st, vecs[i].ft, vecs[i].ol, vecs[i].orr);
      check($sformatf("vec%0d", i), outs(),
            {4'h0, vecs[i].p1, vecs[i].p2, vecs[i].go, vecs[i].dir, vecs[i].ply, vecs[i].ovr});
    end

    // Build a 3/2 game, then pull reset asynchronously between edges.
    serve_wait(); point(1'b0);
    serve_wait(); point(1'b0);
    serve_wait(); point(1'b1);
    serve_wait();
    check("scores_3_2", {8'd0, score_p1, score_p2}, {8'd0, 4'd3, 4'd2});
    #2 rst_n = 1'b0;
    #1 check("async_reset", {outs()[15:1], winner}, 16'd0);
    #1 rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("idle_ignores_out", outs(), 16'd0);

    // Run P2 up to the winning score.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      serve_wait(); point(1'b1);
    end
    serve_wait();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("over_t1", {8'd0, score_p2, 2'd0, game_over, playing}, {8'd0, 4'd8, 4'b0000});
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("over_t2", {13'd0, game_over, winner, playing}, {13'd0, 3'b110});
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("over_shadow", {8'd0, score_p1, score_p2}, {8'd0, 4'd0, 4'd9});
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("over_holds", {7'd0, score_p2, game_over, winner, playing, serve_go, 1'b0},
          {7'd0, 4'd9, 5'b11000});
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_leaves_over", {14'd0, game_over, playing}, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_clear", outs(), 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_tick2", {14'd0, serve_go, playing}, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_serve", {13'd0, serve_go, serve_dir, playing}, {13'd0, 3'b101});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
